// File: rtl/modem_word_serdes_pkg.sv
// Shared constants, types and helpers for the modem word/symbol serialiser.
// Imported by the TX top and the RX deserialiser.
package modem_word_serdes_pkg;

    localparam bit SYM_ORDER_LSB = 1'b0;
    localparam bit SYM_ORDER_MSB = 1'b1;

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // Counter width for a range of `value` states; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/modem_word_serdes_if.sv
// Word/symbol bus between the modem datapath and the serdes.
// The slave view belongs to the serdes, and the master view belongs to its environment.
interface modem_word_serdes_if #(
    parameter int WORD_W = 16,
    parameter int BPS    = 1
);
    logic [WORD_W-1:0] tx_word;
    logic              tx_valid;
    logic              tx_ready;
    logic [BPS-1:0]    sym_out;
    logic              sym_strobe;
    logic              tx_last;
    logic [BPS-1:0]    rx_sym;
    logic              rx_strobe;
    logic              rx_align;
    logic [WORD_W-1:0] rx_word;
    logic              rx_word_valid;

    modport master (
        output tx_word, tx_valid, rx_sym, rx_strobe, rx_align,
        input  tx_ready, sym_out, sym_strobe, tx_last, rx_word, rx_word_valid
    );

    modport slave (
        input  tx_word, tx_valid, rx_sym, rx_strobe, rx_align,
        output tx_ready, sym_out, sym_strobe, tx_last, rx_word, rx_word_valid
    );
endinterface

// File: rtl/modem_word_serdes_symbol_deserializer.sv
// RX path: places each strobed symbol into its slot in the word.
// On the last slot it publishes the completed word with a one-cycle valid pulse.
module symbol_deserializer
    import modem_word_serdes_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int BPS       = 1,
    parameter bit MSB_FIRST = SYM_ORDER_LSB
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [BPS-1:0]    i_rx_sym,
    input  logic              i_rx_strobe,
    input  logic              i_rx_align,
    output logic [WORD_W-1:0] o_rx_word,
    output logic              o_rx_word_valid
);
    localparam int N     = WORD_W / BPS;
    localparam int CNT_W = clog2_min1(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_asm;
    logic [WORD_W-1:0] r_word;
    logic              r_valid;

    logic [CNT_W-1:0]  w_slot;
    logic [CNT_W-1:0]  w_pos;
    logic [WORD_W-1:0] w_asm_next;

    // A strobe that arrives together with an align pulse is taken as symbol 0.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        w_slot     = i_rx_align ? '0 : r_cnt;
        w_pos      = (MSB_FIRST == SYM_ORDER_MSB) ? LAST - w_slot : w_slot;
        w_asm_next = r_asm;
        w_asm_next[int'(w_pos) * BPS +: BPS] = i_rx_sym;
    end

    // NOTE: the assembly register has no reset because each slot is rewritten before a word completes.
    always_ff @(posedge i_clk) begin
        if (i_rx_strobe) r_asm <= w_asm_next;
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments, so each one samples the values from before the edge.
        if (i_reset) begin
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_rx_strobe) begin
                if (w_slot == LAST) begin
                    r_cnt   <= '0;
                    r_word  <= w_asm_next;
                    r_valid <= 1'b1;
                end else begin
                    r_cnt <= w_slot + 1'b1;
                end
            end else if (i_rx_align) begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rx_word       = r_word;
    assign o_rx_word_valid = r_valid;
endmodule

// File: rtl/modem_word_serdes.sv
// Word <-> symbol serdes top. The TX FSM splits each word into BPS-bit symbols, each held for SPS clocks.
// The RX path reassembles incoming symbols into words.
module modem_word_serdes
    import modem_word_serdes_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int BPS       = 1,
    parameter int SPS       = 1,
    parameter bit MSB_FIRST = SYM_ORDER_LSB
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    modem_word_serdes_if.slave bus
);
    localparam int N     = WORD_W / BPS;
    localparam int SYM_W = clog2_min1(N);
    localparam int CLK_W = clog2_min1(SPS);
    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(N - 1);
    localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(SPS - 1);
    localparam bit ONE_SYM_WORD = (N == 1);
    localparam bit ONE_CLK_WORD = (N * SPS == 1);

    if ((WORD_W % BPS) != 0 || SPS < 1) begin : g_param_check
        $error("modem_word_serdes: WORD_W must be a multiple of BPS and SPS must be >= 1");
    end

    tx_state_t         r_state;
    logic [CLK_W-1:0]  r_clk_cnt;
    logic [SYM_W-1:0]  r_sym_cnt;
    logic [WORD_W-1:0] r_word;
    logic [BPS-1:0]    r_sym_out;
    logic              r_sym_strobe;
    logic              r_tx_last;
    logic              r_tx_ready;

    logic              w_accept;
    logic [CLK_W-1:0]  w_clk_inc;
    logic [SYM_W-1:0]  w_sym_inc;

    assign w_accept  = bus.tx_valid & r_tx_ready;
    assign w_clk_inc = r_clk_cnt + 1'b1;
    assign w_sym_inc = r_sym_cnt + 1'b1;

    function automatic logic [BPS-1:0] symbol_at(input logic [WORD_W-1:0] word,
                                                 input logic [SYM_W-1:0]  idx);
        logic [SYM_W-1:0] pos;
        pos = (MSB_FIRST == SYM_ORDER_MSB) ? LAST_SYM - idx : idx;
        return word[int'(pos) * BPS +: BPS];
    endfunction

    // tx_ready is high only in IDLE or on the last clock of a word, so an accept restarts at symbol 0 in either state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= TX_IDLE;
            r_clk_cnt    <= '0;
            r_sym_cnt    <= '0;
            r_sym_out    <= '0;
            r_sym_strobe <= 1'b0;
            r_tx_last    <= 1'b0;
            r_tx_ready   <= 1'b0;
        end else if (w_accept) begin
            r_state      <= TX_SHIFT;
            r_clk_cnt    <= '0;
            r_sym_cnt    <= '0;
            r_word       <= bus.tx_word;
            r_sym_out    <= symbol_at(bus.tx_word, '0);
            r_sym_strobe <= 1'b1;
            r_tx_last    <= ONE_SYM_WORD;
            r_tx_ready   <= ONE_CLK_WORD;
        end else begin
            case (r_state)
                TX_IDLE: r_tx_ready <= 1'b1;
                TX_SHIFT: begin
                    if (r_clk_cnt != LAST_CLK) begin
                        r_clk_cnt    <= w_clk_inc;
                        r_sym_strobe <= 1'b0;
                        r_tx_ready   <= (r_sym_cnt == LAST_SYM) && (w_clk_inc == LAST_CLK);
                    end else if (r_sym_cnt != LAST_SYM) begin
                        r_clk_cnt    <= '0;
                        r_sym_cnt    <= w_sym_inc;
                        r_sym_out    <= symbol_at(r_word, w_sym_inc);
                        r_sym_strobe <= 1'b1;
                        r_tx_last    <= (w_sym_inc == LAST_SYM);
                        r_tx_ready   <= (w_sym_inc == LAST_SYM) && (LAST_CLK == '0);
                    end else begin
                        r_state      <= TX_IDLE;
                        r_clk_cnt    <= '0;
                        r_sym_cnt    <= '0;
                        r_sym_out    <= '0;
                        r_sym_strobe <= 1'b0;
                        r_tx_last    <= 1'b0;
                        r_tx_ready   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.tx_ready   = r_tx_ready;
    assign bus.sym_out    = r_sym_out;
    assign bus.sym_strobe = r_sym_strobe;
    assign bus.tx_last    = r_tx_last;

    symbol_deserializer #(
        .WORD_W   (WORD_W),
        .BPS      (BPS),
        .MSB_FIRST(MSB_FIRST)
    ) u_rx (
        .i_clk          (CLOCK_50),
        .i_reset        (reset),
        .i_rx_sym       (bus.rx_sym),
        .i_rx_strobe    (bus.rx_strobe),
        .i_rx_align     (bus.rx_align),
        .o_rx_word      (bus.rx_word),
        .o_rx_word_valid(bus.rx_word_valid)
    );
endmodule
